// File: rtl/pixel_gen_pipe.sv
// pixel_gen_pipe: two-stage registered compositor for mouse, cursor, grid and text,
// with a frame-counted cursor blink timer running on every clk.
module pixel_gen_pipe #(
  parameter int                 CNT_W        = 10,
  parameter int                 CELL_LOG2    = 5,
  parameter int                 COLOR_W      = 12,
  parameter logic [COLOR_W-1:0] FG_COLOR     = 12'hfff,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 12'h000,
  parameter logic [COLOR_W-1:0] GRID_COLOR   = 12'h333,
  parameter logic [COLOR_W-1:0] CURSOR_COLOR = 12'h0cf,
  parameter logic [COLOR_W-1:0] MOUSE_KEY    = 12'hf0f,
  parameter int                 BLINK_FRAMES = 30
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_pixel_en,
  input  logic                       i_frame_start,
  input  logic                       i_valid,
  input  logic [CNT_W-1:0]           i_h_cnt,
  input  logic [CNT_W-1:0]           i_v_cnt,
  input  logic                       i_enable_mouse_display,
  input  logic [COLOR_W-1:0]         i_mouse_pixel,
  input  logic                       i_mem_pixel,
  input  logic                       i_enable_word_display,
  input  logic                       i_word_pixel,
  input  logic [CNT_W-CELL_LOG2-1:0] i_writing_x,
  input  logic [CNT_W-CELL_LOG2-1:0] i_writing_y,
  input  logic                       i_editing,
  input  logic                       i_grid_en,
  input  logic                       i_invert,
  output logic [COLOR_W-1:0]         o_pixel,
  output logic                       o_pixel_valid
);
  localparam int BW = (BLINK_FRAMES > 0) ? $clog2(BLINK_FRAMES + 1) : 1;
  logic               w_border, w_cur_hit, w_mouse_on;
  logic [COLOR_W-1:0] w_fg, w_bg, w_pixel;
  logic               r_s1_valid, r_s1_border, r_s1_cur_hit, r_s1_mouse_on;
  logic [COLOR_W-1:0] r_s1_mouse_pixel;
  logic               r_s1_mem, r_s1_word_on, r_s1_grid_en, r_s1_invert;
  logic [COLOR_W-1:0] r_pixel;
  logic               r_pixel_valid;
  logic [BW-1:0]      r_blink_cnt;
  logic               r_blink_on, r_editing_d;
  assign w_border = (i_h_cnt[CELL_LOG2-1:0] == '0) || (i_h_cnt[CELL_LOG2-1:0] == '1) ||
                    (i_v_cnt[CELL_LOG2-1:0] == '0) || (i_v_cnt[CELL_LOG2-1:0] == '1);
  assign w_cur_hit = i_editing && (i_h_cnt[CNT_W-1:CELL_LOG2] == i_writing_x) &&
                     (i_v_cnt[CNT_W-1:CELL_LOG2] == i_writing_y);
  assign w_mouse_on = i_enable_mouse_display && (i_mouse_pixel != MOUSE_KEY);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1_valid       <= 1'b0;
      r_s1_border      <= 1'b0;
      r_s1_cur_hit     <= 1'b0;
      r_s1_mouse_on    <= 1'b0;
      r_s1_mouse_pixel <= '0;
      r_s1_mem         <= 1'b0;
      r_s1_word_on     <= 1'b0;
      r_s1_grid_en     <= 1'b0;
      r_s1_invert      <= 1'b0;
      r_pixel          <= '0;
      r_pixel_valid    <= 1'b0;
    end else if (i_pixel_en) begin
      r_s1_valid       <= i_valid;
      r_s1_border      <= w_border;
      r_s1_cur_hit     <= w_cur_hit;
      r_s1_mouse_on    <= w_mouse_on;
      r_s1_mouse_pixel <= i_mouse_pixel;
      r_s1_mem         <= i_mem_pixel;
      r_s1_word_on     <= i_enable_word_display && i_word_pixel;
      r_s1_grid_en     <= i_grid_en;
      r_s1_invert      <= i_invert;
      r_pixel          <= w_pixel;
      r_pixel_valid    <= r_s1_valid;
    end
  assign w_fg = r_s1_invert ? BG_COLOR : FG_COLOR;
  assign w_bg = r_s1_invert ? FG_COLOR : BG_COLOR;
  // Priority: mouse over cursor border, cursor interior, grid, text, background.
  always_comb begin
    w_pixel = !r_s1_valid                  ? '0 :
              r_s1_mouse_on                ? r_s1_mouse_pixel :
              r_s1_cur_hit && r_s1_border  ? (r_blink_on ? CURSOR_COLOR : (r_s1_grid_en ? GRID_COLOR : w_bg)) :
              r_s1_cur_hit                 ? (r_s1_mem ? w_fg : w_bg) :
              r_s1_border && r_s1_grid_en  ? GRID_COLOR :
              r_s1_word_on                 ? w_fg : w_bg;
  end
  // Entering edit mode restarts the blink so the cursor is visible immediately.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_editing_d <= 1'b0;
      r_blink_cnt <= '0;
      r_blink_on  <= 1'b1;
    end else begin
      r_editing_d <= i_editing;
      if (BLINK_FRAMES == 0 || (i_editing && !r_editing_d)) begin
        r_blink_cnt <= '0;
        r_blink_on  <= 1'b1;
      end else if (i_frame_start) begin
        if (r_blink_cnt == BW'(BLINK_FRAMES - 1)) begin
          r_blink_cnt <= '0;
          r_blink_on  <= !r_blink_on;
        end else r_blink_cnt <= r_blink_cnt + 1'b1;
      end
    end
  assign o_pixel       = r_pixel;
  assign o_pixel_valid = r_pixel_valid;
endmodule

// File: tb/tb_pixel_gen_pipe.sv
// tb_pixel_gen_pipe: randomized and directed checks of pixel_gen_pipe against a
// rule-level model that evaluates raw sampled inputs at output time.
module tb_pixel_gen_pipe;
  localparam int BF = 2;
  typedef struct packed {
    logic valid; logic [9:0] h, v; logic men; logic [11:0] mpx;
    logic mem, wen, wpx; logic [4:0] wx, wy; logic ed, grid, inv;
  } snap_t;
  logic clk = 0, rst_n = 0;
  logic pixel_en = 0, frame_start = 0, valid = 0, men = 0, mem = 0, wen = 0, wpx = 0;
  logic editing = 0, grid = 0, inv = 0;
  logic [9:0] h = 0, v = 0;
  logic [11:0] mpx = 0;
  logic [4:0] wx = 0, wy = 0;
  logic [11:0] o_pixel;
  logic o_pixel_valid;
  int n_checks = 0, n_fail = 0;
  bit chk_en = 0;
  snap_t m_s1;
  logic [11:0] m_pix;
  logic m_pv, m_bon, m_ed;
  int m_bcnt;
  int on_exp[7] = '{1, 0, 0, 1, 1, 0, 0};
  int cnt_exp[7] = '{1, 0, 1, 0, 1, 0, 1};
  pixel_gen_pipe #(.BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst_n(rst_n), .i_pixel_en(pixel_en), .i_frame_start(frame_start),
    .i_valid(valid), .i_h_cnt(h), .i_v_cnt(v), .i_enable_mouse_display(men),
    .i_mouse_pixel(mpx), .i_mem_pixel(mem), .i_enable_word_display(wen),
    .i_word_pixel(wpx), .i_writing_x(wx), .i_writing_y(wy), .i_editing(editing),
    .i_grid_en(grid), .i_invert(inv), .o_pixel(o_pixel), .o_pixel_valid(o_pixel_valid)
  );
  always #5 clk = ~clk;
  function automatic logic [11:0] ref_pix(snap_t s, logic blink);
    int hm, vm;
    logic border, cur, mouse;
    logic [11:0] fg, bg;
    hm = int'(s.h) % 32;
    vm = int'(s.v) % 32;
    border = hm == 0 || hm == 31 || vm == 0 || vm == 31;
    cur = s.ed && (int'(s.h) / 32 == int'(s.wx)) && (int'(s.v) / 32 == int'(s.wy));
    mouse = s.men && s.mpx != 12'hf0f;
    fg = s.inv ? 12'h000 : 12'hfff;
    bg = s.inv ? 12'hfff : 12'h000;
    if (!s.valid) return 12'h000;
    if (mouse) return s.mpx;
    if (cur && border) return blink ? 12'h0cf : (s.grid ? 12'h333 : bg);
    if (cur) return s.mem ? fg : bg;
    if (border && s.grid) return 12'h333;
    if (s.wen && s.wpx) return fg;
    return bg;
  endfunction
  function automatic snap_t sample();
    return '{valid, h, v, men, mpx, mem, wen, wpx, wx, wy, editing, grid, inv};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_s1 <= '0; m_pix <= '0; m_pv <= 0; m_bon <= 1; m_bcnt <= 0; m_ed <= 0;
    end else begin
      if (pixel_en) begin
        m_pix <= ref_pix(m_s1, m_bon);
        m_pv  <= m_s1.valid;
        m_s1  <= sample();
      end
      m_ed <= editing;
      if (editing && !m_ed) begin
        m_bon <= 1; m_bcnt <= 0;
      end else if (frame_start) begin
        if (m_bcnt == BF - 1) begin
          m_bcnt <= 0; m_bon <= !m_bon;
        end else m_bcnt <= m_bcnt + 1;
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("pixel", 32'(o_pixel), 32'(m_pix));
      chk("pixel_valid", 32'(o_pixel_valid), 32'(m_pv));
      chk("blink_on", 32'(dut.r_blink_on), 32'(m_bon));
      chk("blink_cnt", 32'(dut.r_blink_cnt), 32'(m_bcnt));
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic lit(input string name, input logic [11:0] exp);
    chk({name, "_dut"}, 32'(o_pixel), 32'(exp));
    chk({name, "_model"}, 32'(m_pix), 32'(exp));
  endtask
  initial begin
    pixel_en = 1;
    step(3);
    chk("rst_pixel", 32'(o_pixel), 0);
    chk("rst_valid", 32'(o_pixel_valid), 0);
    chk("rst_blink_on", 32'(dut.r_blink_on), 1);
    chk_en = 1;
    rst_n = 1; valid = 1; h = 64; v = 32; editing = 1; wx = 2; wy = 1;
    step(2);
    lit("cursor_border", 12'h0cf);
    chk("cursor_valid", 32'(o_pixel_valid), 1);
    h = 70; v = 40; mem = 1;
    step(2);
    lit("cursor_fg", 12'hfff);
    inv = 1;
    step(2);
    lit("cursor_fg_inv", 12'h000);
    repeat (2) begin
      frame_start = 1; step(1); frame_start = 0; step(1);
    end
    chk("blink_off", 32'(dut.r_blink_on), 0);
    h = 64; v = 32; grid = 1;
    step(2);
    lit("cursor_off_grid", 12'h333);
    grid = 0;
    step(2);
    lit("cursor_off_bg_inv", 12'hfff);
    editing = 0; inv = 0; grid = 1; h = 0; v = 5; men = 1; mpx = 12'hf0f;
    step(2);
    lit("mouse_key", 12'h333);
    mpx = 12'h123;
    step(2);
    lit("mouse_color", 12'h123);
    men = 0; editing = 1;
    step(1);
    for (int i = 0; i < 7; i++) begin
      frame_start = 1; step(1); frame_start = 0;
      chk($sformatf("pulse%0d_on", i + 1), 32'(dut.r_blink_on), 32'(on_exp[i]));
      chk($sformatf("pulse%0d_cnt", i + 1), 32'(dut.r_blink_cnt), 32'(cnt_exp[i]));
      step(1);
    end
    editing = 0; step(1);
    editing = 1; frame_start = 1; step(1); frame_start = 0;
    chk("edge_prio_on", 32'(dut.r_blink_on), 1);
    chk("edge_prio_cnt", 32'(dut.r_blink_cnt), 0);
    valid = 0;
    step(2);
    lit("invalid", 12'h000);
    chk("invalid_valid", 32'(o_pixel_valid), 0);
    valid = 1; editing = 0; men = 1; mpx = 12'h456;
    for (int e = 0; e < 2; e++) begin
      pixel_en = 1; step(1); pixel_en = 0; step(3);
      if (e == 0) lit("en_wait", 12'h000);
    end
    lit("en_latency", 12'h456);
    chk("en_valid", 32'(o_pixel_valid), 1);
    #2 rst_n = 0;
    #1 chk("async_pixel", 32'(o_pixel), 0);
    chk("async_valid", 32'(o_pixel_valid), 0);
    step(1); rst_n = 1; step(1);
    chk("post_rst_blink", 32'(dut.r_blink_on), 1);
    for (int i = 0; i < 4000; i++) begin
      pixel_en = $urandom_range(0, 9) < 7;
      frame_start = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 49) == 0) editing = ~editing;
      rst_n = $urandom_range(0, 499) != 0;
      valid = $urandom_range(0, 7) != 0;
      wx = 5'($urandom); wy = 5'($urandom);
      h = $urandom_range(0, 1) ? {wx, 5'($urandom)} : 10'($urandom);
      v = $urandom_range(0, 1) ? {wy, 5'($urandom)} : 10'($urandom);
      if ($urandom_range(0, 3) == 0) h[4:0] = $urandom_range(0, 1) ? 5'd31 : 5'd0;
      men = $urandom_range(0, 3) == 0;
      mpx = $urandom_range(0, 2) == 0 ? 12'hf0f : 12'($urandom);
      mem = 1'($urandom); wen = 1'($urandom); wpx = 1'($urandom);
      grid = 1'($urandom); inv = 1'($urandom);
      step(1);
    end
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_gen_pipe.md
Name: pixel_gen_pipe

Overview:
Registered, parametrised successor to the combinational pixel generator in the VGA display path. It sits between the VGA timing/mouse/memory readers and the RGB output pins. It composites mouse overlay, editing cursor, character grid and word text into one colour word through a fixed 2-stage pipeline. It adds a frame-counted blinking cursor, mouse colour-key transparency, grid/invert modes and a generalised cell size and colour width.

Parameters:
CNT_W, 10, width of h_cnt/v_cnt
CELL_LOG2, 5, log2 of square cell size in pixels (5 = 32x32 cells)
COLOR_W, 12, colour word width (4:4:4 RGB at default)
FG_COLOR, 12'hfff, text foreground
BG_COLOR, 12'h000, text background
GRID_COLOR, 12'h333, grid line colour
CURSOR_COLOR, 12'h0cf, cursor border colour while blink phase is on
MOUSE_KEY, 12'hf0f, mouse_pixel value treated as transparent
BLINK_FRAMES, 30, frames per blink half-period; 0 disables blinking (always on)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pixel_en  in  1  pixel-rate clock enable; pipeline advances only when high
frame_start  in  1  one-clk pulse at start of each frame (independent of pixel_en)
valid  in  1  active-video flag aligned with h_cnt/v_cnt
h_cnt  in  CNT_W  horizontal pixel counter
v_cnt  in  CNT_W  vertical pixel counter
enable_mouse_display  in  1  mouse sprite covers this pixel
mouse_pixel  in  COLOR_W  mouse sprite colour
mem_pixel  in  1  edit-buffer bit for this pixel
enable_word_display  in  1  word text enabled
word_pixel  in  1  word glyph bit for this pixel
writing_x  in  CNT_W-CELL_LOG2  cursor cell column
writing_y  in  CNT_W-CELL_LOG2  cursor cell row
editing  in  1  edit mode active
grid_en  in  1  draw grid lines
invert  in  1  swap FG/BG for text and cursor interior
pixel  out  COLOR_W  registered output colour
pixel_valid  out  1  registered valid, aligned with pixel

Behaviour:
- Reset (async, rst_n=0): pixel=0, pixel_valid=0, all pipeline registers 0, blink_cnt=0, blink_on=1, editing_d=0. Release is synchronous to clk.
- Pipeline: all data inputs are sampled together. Latency is exactly 2 pixel_en cycles. When pixel_en=0, all pipeline registers hold, including pixel and pixel_valid.
- Stage 1, on pixel_en, registers:
  - valid
  - border = (h_cnt[CELL_LOG2-1:0] is 0 or all-ones) or (v_cnt[CELL_LOG2-1:0] is 0 or all-ones)
  - cur_hit = editing and h_cnt[CNT_W-1:CELL_LOG2]==writing_x and v_cnt[CNT_W-1:CELL_LOG2]==writing_y
  - mouse_on = enable_mouse_display and mouse_pixel != MOUSE_KEY
  - mouse_pixel, mem_pixel, word_on = enable_word_display and word_pixel
  - grid_en, invert
- Stage 2, on pixel_en: pixel_valid = s1 valid. pixel is chosen by first match:
  1. not valid -> 0
  2. mouse_on -> mouse_pixel
  3. cur_hit and border -> blink_on ? CURSOR_COLOR : (grid_en ? GRID_COLOR : BG')
  4. cur_hit -> mem_pixel ? FG' : BG'
  5. border and grid_en -> GRID_COLOR
  6. word_on -> FG'
  7. otherwise -> BG'
  - FG'/BG' = FG_COLOR/BG_COLOR, swapped when invert=1.
- Blink timer (clk domain, ignores pixel_en):
  - editing_d <= editing every clk.
  - Rising edge of editing (editing=1, editing_d=0): blink_cnt=0 and blink_on=1. This has priority over a simultaneous frame_start.
  - Otherwise on frame_start: if blink_cnt==BLINK_FRAMES-1, then blink_cnt=0 and blink_on toggles; else blink_cnt increments.
  - BLINK_FRAMES=0: blink_cnt stays 0 and blink_on stays 1.
  - blink_cnt width is clog2(BLINK_FRAMES+1); it must never exceed BLINK_FRAMES-1.
- blink_on is read directly in stage 2, not pipelined. A change takes effect on the next pixel_en stage-2 update.
- Cursor cell comparison uses full-width equality. A cursor coordinate outside the screen never matches; this is not an error.
- Reset asserted mid-frame forces pixel=0 immediately (asynchronously). The first valid output appears 2 pixel_en cycles after release.

Test Plan:
- Reset, then valid=1, h=64, v=32, editing=1, writing_x=2, writing_y=1, pixel_en every clk -> pixel=12'h0cf on the 2nd cycle; pixel_valid=1; h=70, v=40, mem_pixel=1 -> 12'hfff.
- Same cursor pixel with invert=1 and mem_pixel=1 -> 12'h000; border with blink_on=0 and grid_en=1 -> 12'h333; with grid_en=0 -> 12'hfff (BG' under invert).
- enable_mouse_display=1, mouse_pixel=12'hf0f on a grid border with grid_en=1 -> 12'h333 (transparent); mouse_pixel=12'h123 -> 12'h123.
- BLINK_FRAMES=2, editing held: blink_on toggles after every 2nd frame_start (1->0 after pulse 2, 0->1 after pulse 4); editing 0->1 together with frame_start -> blink_on=1, blink_cnt=0.
- pixel_en pulsing 1-in-4 -> output stays stable between enables; latency is 2 enables (8 clks); valid=0 -> pixel=0, pixel_valid=0.
- Assert rst_n=0 mid-line -> pixel=0 and pixel_valid=0 without a clock edge; blink_on=1 after release.
